// File: rtl/param_seq_controller.sv
// Variable-length T-state control sequencer for the accumulator CPU: a shared
// three-state fetch followed by one to three opcode-selected execute states.
module param_seq_controller #(
    parameter int OP_W     = 4,
    parameter int CNT_W    = 8,
    parameter int MEM_WAIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             mem_ready,
    input  logic [OP_W-1:0]  opcode,
    output logic             pc_out,
    output logic             mar_load_pc,
    output logic             pc_inc,
    output logic             mem_rd,
    output logic             ir_load,
    output logic             mar_load_ir,
    output logic             a_load_mem,
    output logic             a_load_alu,
    output logic             a_load_b,
    output logic             tmp_load_a,
    output logic             b_load_tmp,
    output logic             alu_en,
    output logic [1:0]       alu_op,
    output logic             out_load,
    output logic [5:0]       t_state,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {S_T1, S_T2, S_T3, S_E1, S_E2, S_E3, S_HALT} state_t;

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(4'b0001);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(4'b0010);
    localparam logic [OP_W-1:0] OP_XCHG = OP_W'(4'b0011);
    localparam logic [OP_W-1:0] OP_MOV  = OP_W'(4'b0111);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(4'b1000);
    localparam logic [OP_W-1:0] OP_HLT  = OP_W'(4'b1110);
    localparam logic [OP_W-1:0] OP_OUT  = OP_W'(4'b1111);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   instr_count_q, instr_count_d;
    logic               count_inc;
    logic               stall;
    logic [1:0]         alu_sel;

    // mem_ready is a one-way ready: a read state holds with mem_rd asserted
    // until the RAM raises mem_ready, and the read completes on that edge.
    assign stall = (MEM_WAIT != 0) && !mem_ready;

    always_comb begin
        alu_sel = 2'b00;
        case (opcode)
            OP_SUB:  alu_sel = 2'b01;
            OP_AND:  alu_sel = 2'b10;
            default: alu_sel = 2'b00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        count_inc   = 1'b0;
        pc_out      = 1'b0;
        mar_load_pc = 1'b0;
        pc_inc      = 1'b0;
        mem_rd      = 1'b0;
        ir_load     = 1'b0;
        mar_load_ir = 1'b0;
        a_load_mem  = 1'b0;
        a_load_alu  = 1'b0;
        a_load_b    = 1'b0;
        tmp_load_a  = 1'b0;
        b_load_tmp  = 1'b0;
        alu_en      = 1'b0;
        alu_op      = 2'b00;
        out_load    = 1'b0;
        case (state_q)
            S_T1: begin
                if (run) begin
                    pc_out      = 1'b1;
                    mar_load_pc = 1'b1;
                    state_d     = S_T2;
                end
            end
            S_T2: begin
                pc_inc  = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                mem_rd  = 1'b1;
                ir_load = 1'b1;
                if (!stall) state_d = S_E1;
            end
            S_E1: begin
                case (opcode)
                    OP_MOV: begin
                        mar_load_ir = 1'b1;
                        state_d     = S_E2;
                    end
                    OP_XCHG: begin
                        tmp_load_a = 1'b1;
                        state_d    = S_E2;
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        alu_en  = 1'b1;
                        alu_op  = alu_sel;
                        state_d = S_E2;
                    end
                    OP_OUT: begin
                        out_load  = 1'b1;
                        count_inc = 1'b1;
                        state_d   = S_T1;
                    end
                    OP_HLT: begin
                        count_inc = 1'b1;
                        state_d   = S_HALT;
                    end
                    default: begin
                        count_inc = 1'b1;
                        state_d   = S_T1;
                    end
                endcase
            end
            S_E2: begin
                case (opcode)
                    OP_MOV: begin
                        mem_rd     = 1'b1;
                        a_load_mem = 1'b1;
                        if (!stall) begin
                            count_inc = 1'b1;
                            state_d   = S_T1;
                        end
                    end
                    OP_XCHG: begin
                        a_load_b = 1'b1;
                        state_d  = S_E3;
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        alu_en     = 1'b1;
                        alu_op     = alu_sel;
                        a_load_alu = 1'b1;
                        count_inc  = 1'b1;
                        state_d    = S_T1;
                    end
                    default: begin
                        count_inc = 1'b1;
                        state_d   = S_T1;
                    end
                endcase
            end
            S_E3: begin
                b_load_tmp = 1'b1;
                count_inc  = 1'b1;
                state_d    = S_T1;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_T1;
        endcase
    end

    assign instr_count_d = count_inc ? instr_count_q + CNT_W'(1) : instr_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_T1;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_comb begin
        t_state = 6'b000000;
        case (state_q)
            S_T1:    t_state = 6'b000001;
            S_T2:    t_state = 6'b000010;
            S_T3:    t_state = 6'b000100;
            S_E1:    t_state = 6'b001000;
            S_E2:    t_state = 6'b010000;
            S_E3:    t_state = 6'b100000;
            default: t_state = 6'b000000;
        endcase
    end

    assign halted      = (state_q == S_HALT);
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_param_seq_controller.sv
// Directed bench for param_seq_controller: each cycle's expected outputs are
// queued by the driver and compared by a negedge monitor.
module tb_param_seq_controller;

    logic       clk = 1'b0;
    logic       reset, run, mem_ready;
    logic [3:0] opcode;
    logic       pc_out, mar_load_pc, pc_inc, mem_rd, ir_load, mar_load_ir;
    logic       a_load_mem, a_load_alu, a_load_b, tmp_load_a, b_load_tmp;
    logic       alu_en, out_load, halted;
    logic [1:0] alu_op;
    logic [5:0] t_state;
    logic [7:0] instr_count;

    // Control vector bit order (MSB first): pc_out, mar_load_pc, pc_inc,
    // mem_rd, ir_load, mar_load_ir, a_load_mem, a_load_alu, a_load_b,
    // tmp_load_a, b_load_tmp, alu_en, alu_op[1:0], out_load.
    localparam logic [14:0] C_NONE  = 15'b000_0000_0000_0000;
    localparam logic [14:0] C_F1    = 15'b110_0000_0000_0000;
    localparam logic [14:0] C_F2    = 15'b001_0000_0000_0000;
    localparam logic [14:0] C_F3    = 15'b000_1100_0000_0000;
    localparam logic [14:0] C_MARIR = 15'b000_0010_0000_0000;
    localparam logic [14:0] C_MOVE2 = 15'b000_1001_0000_0000;
    localparam logic [14:0] C_TMPA  = 15'b000_0000_0010_0000;
    localparam logic [14:0] C_AB    = 15'b000_0000_0100_0000;
    localparam logic [14:0] C_BTMP  = 15'b000_0000_0001_0000;
    localparam logic [14:0] C_SUB1  = 15'b000_0000_0000_1010;
    localparam logic [14:0] C_SUB2  = 15'b000_0000_1000_1010;
    localparam logic [14:0] C_AND1  = 15'b000_0000_0000_1100;
    localparam logic [14:0] C_AND2  = 15'b000_0000_1000_1100;
    localparam logic [14:0] C_OUT   = 15'b000_0000_0000_0001;

    localparam logic [5:0] ST_T1 = 6'b000001, ST_T2 = 6'b000010, ST_T3 = 6'b000100;
    localparam logic [5:0] ST_E1 = 6'b001000, ST_E2 = 6'b010000, ST_E3 = 6'b100000;
    localparam logic [5:0] ST_H  = 6'b000000;

    logic [29:0] exp_q[$];
    int          tag_q[$];
    int          step_no = 0;
    int          checks  = 0;
    int          errors  = 0;

    param_seq_controller #(.OP_W(4), .CNT_W(8), .MEM_WAIT(1)) dut (
        .clk(clk), .reset(reset), .run(run), .mem_ready(mem_ready), .opcode(opcode),
        .pc_out(pc_out), .mar_load_pc(mar_load_pc), .pc_inc(pc_inc), .mem_rd(mem_rd),
        .ir_load(ir_load), .mar_load_ir(mar_load_ir), .a_load_mem(a_load_mem),
        .a_load_alu(a_load_alu), .a_load_b(a_load_b), .tmp_load_a(tmp_load_a),
        .b_load_tmp(b_load_tmp), .alu_en(alu_en), .alu_op(alu_op), .out_load(out_load),
        .t_state(t_state), .halted(halted), .instr_count(instr_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    // driver: apply one cycle of inputs and queue the outputs expected for it
    task automatic step(input logic rst, input logic r, input logic mr, input logic [3:0] op,
                        input logic [5:0] t, input logic [14:0] c, input logic h,
                        input logic [7:0] n);
        reset     = rst;
        run       = r;
        mem_ready = mr;
        opcode    = op;
        exp_q.push_back({t, c, h, n});
        tag_q.push_back(step_no);
        step_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [3:0] op, input logic [7:0] n);
        step(1'b1, 1'b1, 1'b1, op, ST_T1, C_F1, 1'b0, n);
        step(1'b1, 1'b1, 1'b1, op, ST_T2, C_F2, 1'b0, n);
        step(1'b1, 1'b1, 1'b1, op, ST_T3, C_F3, 1'b0, n);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [29:0] act, exp_v;
        int          tag;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            tag   = tag_q.pop_front();
            act   = {t_state, pc_out, mar_load_pc, pc_inc, mem_rd, ir_load, mar_load_ir,
                     a_load_mem, a_load_alu, a_load_b, tmp_load_a, b_load_tmp, alu_en,
                     alu_op, out_load, halted, instr_count};
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL step %0d: got t_state=%b ctrl=%b halted=%b count=%0d, expected t_state=%b ctrl=%b halted=%b count=%0d",
                         tag, act[29:24], act[23:9], act[8], act[7:0],
                         exp_v[29:24], exp_v[23:9], exp_v[8], exp_v[7:0]);
            end
        end
    end

    initial begin
        logic [7:0] cnt;
        reset = 1'b0; run = 1'b0; mem_ready = 1'b1; opcode = 4'h0;
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 1'b1, 4'h0, ST_T1, C_NONE, 1'b0, 8'd0);

        // MOV A,addr
        fetch(4'b0111, 8'd0);
        step(1'b1, 1'b1, 1'b1, 4'b0111, ST_E1, C_MARIR, 1'b0, 8'd0);
        step(1'b1, 1'b1, 1'b1, 4'b0111, ST_E2, C_MOVE2, 1'b0, 8'd0);
        // XCHG A,B
        fetch(4'b0011, 8'd1);
        step(1'b1, 1'b1, 1'b1, 4'b0011, ST_E1, C_TMPA, 1'b0, 8'd1);
        step(1'b1, 1'b1, 1'b1, 4'b0011, ST_E2, C_AB,   1'b0, 8'd1);
        step(1'b1, 1'b1, 1'b1, 4'b0011, ST_E3, C_BTMP, 1'b0, 8'd1);
        // SUB, AND
        fetch(4'b0010, 8'd2);
        step(1'b1, 1'b1, 1'b1, 4'b0010, ST_E1, C_SUB1, 1'b0, 8'd2);
        step(1'b1, 1'b1, 1'b1, 4'b0010, ST_E2, C_SUB2, 1'b0, 8'd2);
        fetch(4'b1000, 8'd3);
        step(1'b1, 1'b1, 1'b1, 4'b1000, ST_E1, C_AND1, 1'b0, 8'd3);
        step(1'b1, 1'b1, 1'b1, 4'b1000, ST_E2, C_AND2, 1'b0, 8'd3);
        // OUT, NOP
        fetch(4'b1111, 8'd4);
        step(1'b1, 1'b1, 1'b1, 4'b1111, ST_E1, C_OUT, 1'b0, 8'd4);
        fetch(4'b0000, 8'd5);
        step(1'b1, 1'b1, 1'b1, 4'b0000, ST_E1, C_NONE, 1'b0, 8'd5);
        // MOV with three T3 wait cycles and one E2 wait cycle
        step(1'b1, 1'b1, 1'b1, 4'b0111, ST_T1, C_F1, 1'b0, 8'd6);
        step(1'b1, 1'b1, 1'b1, 4'b0111, ST_T2, C_F2, 1'b0, 8'd6);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b0, 4'b0111, ST_T3, C_F3, 1'b0, 8'd6);
        step(1'b1, 1'b1, 1'b1, 4'b0111, ST_T3, C_F3,    1'b0, 8'd6);
        step(1'b1, 1'b1, 1'b1, 4'b0111, ST_E1, C_MARIR, 1'b0, 8'd6);
        step(1'b1, 1'b1, 1'b0, 4'b0111, ST_E2, C_MOVE2, 1'b0, 8'd6);
        step(1'b1, 1'b1, 1'b1, 4'b0111, ST_E2, C_MOVE2, 1'b0, 8'd6);
        // run gate, then HLT
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 1'b1, 4'b1110, ST_T1, C_NONE, 1'b0, 8'd7);
        fetch(4'b1110, 8'd7);
        step(1'b1, 1'b1, 1'b1, 4'b1110, ST_E1, C_NONE, 1'b0, 8'd7);
        step(1'b1, 1'b1, 1'b1, 4'b1110, ST_H, C_NONE, 1'b1, 8'd8);
        step(1'b1, 1'b0, 1'b0, 4'b0000, ST_H, C_NONE, 1'b1, 8'd8);
        step(1'b1, 1'b1, 1'b1, 4'b0111, ST_H, C_NONE, 1'b1, 8'd8);
        // reset out of HALT, then reset during a stalled MOV E2
        step(1'b0, 1'b0, 1'b1, 4'b0111, ST_T1, C_NONE, 1'b0, 8'd0);
        fetch(4'b0111, 8'd0);
        step(1'b1, 1'b1, 1'b1, 4'b0111, ST_E1, C_MARIR, 1'b0, 8'd0);
        step(1'b1, 1'b1, 1'b0, 4'b0111, ST_E2, C_MOVE2, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 4'b0111, ST_T1, C_NONE,  1'b0, 8'd0);
        // counter wraps after 256 NOPs
        cnt = 8'd0;
        for (int i = 0; i < 257; i++) begin
            fetch(4'b0000, cnt);
            step(1'b1, 1'b1, 1'b1, 4'b0000, ST_E1, C_NONE, 1'b0, cnt);
            cnt = cnt + 8'd1;
        end
        step(1'b1, 1'b0, 1'b1, 4'b0000, ST_T1, C_NONE, 1'b0, cnt);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
